// File: rtl/control_pkg.sv
// Shared types and constants for the microcontroller sequencer.
// Holds the FSM state enum, instruction class/op codes and memory RW levels.
package control_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_DEC,
    ST_A1,
    ST_A2,
    ST_A3,
    ST_A4,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_I1,
    ST_I2,
    ST_OUT,
    ST_MOV,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic CLS_ALU  = 1'b0;
  localparam logic CLS_MISC = 1'b1;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_IN    = 3'b010;
  localparam logic [2:0] OP_OUT   = 3'b011;
  localparam logic [2:0] OP_MOV   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int NREG   = 4;
  localparam int WCNT_W = 16;

endpackage

// File: rtl/reg_sel_decoder.sv
// 2-to-4 one-hot decoder with enable for general-register strobes.
// Ports: i_en enable, i_sel register index, o_onehot bit n = register n.
module reg_sel_decoder
  import control_pkg::*;
(
  input  logic            i_en,
  input  logic [1:0]      i_sel,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch-decode-execute sequencer driving all datapath strobes.
// Ports: clk/rst, ir word, MFC handshake in; ALU/G/PC/port/MAR/MDR/mem/IR strobes, halted, fault out.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        MFC,
  output logic        ALUin1,
  output logic        ALUin2,
  output logic        ALU_outlach,
  output logic        ALU_outEN,
  output logic [3:0]  G_in,
  output logic [3:0]  G_out,
  output logic        PC_Out,
  output logic        PC_inc,
  output logic        P0_in,
  output logic        P0_out,
  output logic        P1_in,
  output logic        P1_out,
  output logic        MAR_EN,
  output logic        MDR_EN_write,
  output logic        MDR_EN_read,
  output logic        MDR_out,
  output logic        mem_EN,
  output logic        mem_RW,
  output logic        IR_EN,
  output logic        halted,
  output logic        fault
);

  localparam logic [WCNT_W-1:0] LP_WLIM =
    (WAIT_MAX == 0) ? '0 : WCNT_W'(WAIT_MAX - 1);

  state_t            r_state;
  logic [WCNT_W-1:0] r_wait;

  logic       w_cls;
  logic [2:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic       w_timeout;
  logic       w_gi_en;
  logic [1:0] w_gi_sel;
  logic       w_go_en;
  logic [1:0] w_go_sel;

  assign w_cls = ir[15];
  assign w_op  = ir[14:12];
  assign w_rd  = ir[11:10];
  assign w_rs  = ir[9:8];

  // Watchdog expires on the last allowed wait cycle if MFC is still low.
  assign w_timeout = (WAIT_MAX != 0) && (r_wait == LP_WLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: r_state <= ST_F0;
        ST_F0: begin
          r_state <= ST_F1;
          r_wait  <= '0;
        end
        ST_F1: begin
          if (MFC)            r_state <= ST_F2;
          else if (w_timeout) r_state <= ST_FAULT;
          else                r_wait  <= r_wait + 1'b1;
        end
        ST_F2:  r_state <= ST_DEC;
        ST_DEC: begin
          if (w_cls == CLS_ALU) begin
            r_state <= ST_A1;
          end else begin
            unique case (w_op)
              OP_LOAD:  r_state <= ST_L1;
              OP_STORE: r_state <= ST_S1;
              OP_IN:    r_state <= ST_I1;
              OP_OUT:   r_state <= ST_OUT;
              OP_MOV:   r_state <= ST_MOV;
              OP_HALT:  r_state <= ST_HALT;
              default:  r_state <= ST_F0;
            endcase
          end
        end
        ST_A1: r_state <= ST_A2;
        ST_A2: r_state <= ST_A3;
        ST_A3: r_state <= ST_A4;
        ST_A4: r_state <= ST_F0;
        ST_L1: begin
          r_state <= ST_L2;
          r_wait  <= '0;
        end
        ST_L2: begin
          if (MFC)            r_state <= ST_L3;
          else if (w_timeout) r_state <= ST_FAULT;
          else                r_wait  <= r_wait + 1'b1;
        end
        ST_L3: r_state <= ST_F0;
        ST_S1: r_state <= ST_S2;
        ST_S2: begin
          r_state <= ST_S3;
          r_wait  <= '0;
        end
        ST_S3: begin
          if (MFC)            r_state <= ST_F0;
          else if (w_timeout) r_state <= ST_FAULT;
          else                r_wait  <= r_wait + 1'b1;
        end
        ST_I1:    r_state <= ST_I2;
        ST_I2:    r_state <= ST_F0;
        ST_OUT:   r_state <= ST_F0;
        ST_MOV:   r_state <= ST_F0;
        ST_HALT:  r_state <= ST_HALT;
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of state; only MDR_EN_read also looks at MFC.
  always_comb begin
    ALUin1       = 1'b0;
    ALUin2       = 1'b0;
    ALU_outlach  = 1'b0;
    ALU_outEN    = 1'b0;
    PC_Out       = 1'b0;
    PC_inc       = 1'b0;
    P0_in        = 1'b0;
    P0_out       = 1'b0;
    P1_in        = 1'b0;
    P1_out       = 1'b0;
    MAR_EN       = 1'b0;
    MDR_EN_write = 1'b0;
    MDR_EN_read  = 1'b0;
    MDR_out      = 1'b0;
    mem_EN       = 1'b0;
    mem_RW       = 1'b0;
    IR_EN        = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    w_gi_en      = 1'b0;
    w_gi_sel     = w_rd;
    w_go_en      = 1'b0;
    w_go_sel     = w_rs;
    unique case (r_state)
      ST_F0: begin
        PC_Out = 1'b1;
        MAR_EN = 1'b1;
      end
      ST_F1, ST_L2: begin
        mem_EN      = 1'b1;
        mem_RW      = MEM_READ;
        MDR_EN_read = MFC;
      end
      ST_F2: begin
        MDR_out = 1'b1;
        IR_EN   = 1'b1;
        PC_inc  = 1'b1;
      end
      ST_A1: begin
        w_go_en  = 1'b1;
        w_go_sel = w_rd;
        ALUin1   = 1'b1;
      end
      ST_A2: begin
        w_go_en = 1'b1;
        ALUin2  = 1'b1;
      end
      ST_A3: ALU_outlach = 1'b1;
      ST_A4: begin
        ALU_outEN = 1'b1;
        w_gi_en   = 1'b1;
      end
      ST_L1, ST_S1: begin
        w_go_en = 1'b1;
        MAR_EN  = 1'b1;
      end
      ST_L3: begin
        MDR_out = 1'b1;
        w_gi_en = 1'b1;
      end
      ST_S2: begin
        w_go_en      = 1'b1;
        w_go_sel     = w_rd;
        MDR_EN_write = 1'b1;
      end
      ST_S3: begin
        mem_EN = 1'b1;
        mem_RW = MEM_WRITE;
      end
      ST_I1: P1_in = 1'b1;
      ST_I2: begin
        P1_out  = 1'b1;
        w_gi_en = 1'b1;
      end
      ST_OUT: begin
        w_go_en = 1'b1;
        P0_in   = 1'b1;
      end
      ST_MOV: begin
        w_go_en = 1'b1;
        w_gi_en = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  reg_sel_decoder u_gin (
    .i_en     (w_gi_en),
    .i_sel    (w_gi_sel),
    .o_onehot (G_in)
  );

  reg_sel_decoder u_gout (
    .i_en     (w_go_en),
    .i_sel    (w_go_sel),
    .o_onehot (G_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors per instruction.
// Watchdog instance uses WAIT_MAX=4.
module tb_control_unit;

  typedef logic [26:0] ov_t;

  localparam ov_t ALI1 = ov_t'(1) << 26;
  localparam ov_t ALI2 = ov_t'(1) << 25;
  localparam ov_t ALOL = ov_t'(1) << 24;
  localparam ov_t ALOE = ov_t'(1) << 23;
  localparam ov_t PCO  = ov_t'(1) << 14;
  localparam ov_t PCI  = ov_t'(1) << 13;
  localparam ov_t P0I  = ov_t'(1) << 12;
  localparam ov_t P1I  = ov_t'(1) << 10;
  localparam ov_t P1O  = ov_t'(1) << 9;
  localparam ov_t MAR  = ov_t'(1) << 8;
  localparam ov_t MDW  = ov_t'(1) << 7;
  localparam ov_t MDR  = ov_t'(1) << 6;
  localparam ov_t MDO  = ov_t'(1) << 5;
  localparam ov_t MEN  = ov_t'(1) << 4;
  localparam ov_t MRW  = ov_t'(1) << 3;
  localparam ov_t IRE  = ov_t'(1) << 2;
  localparam ov_t HLT  = ov_t'(1) << 1;
  localparam ov_t FLT  = ov_t'(1);
  localparam ov_t Z    = '0;
  localparam ov_t F0   = PCO | MAR;
  localparam ov_t F1   = MEN | MRW | MDR;
  localparam ov_t F2   = MDO | IRE | PCI;

  function automatic ov_t GI(input int n);
    return ov_t'(1) << (19 + n);
  endfunction

  function automatic ov_t GO(input int n);
    return ov_t'(1) << (15 + n);
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir  = '0;
  logic        MFC = 1'b1;
  logic        ALUin1, ALUin2, ALU_outlach, ALU_outEN;
  logic [3:0]  G_in, G_out;
  logic        PC_Out, PC_inc, P0_in, P0_out, P1_in, P1_out;
  logic        MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out;
  logic        mem_EN, mem_RW, IR_EN, halted, fault;
  ov_t         obs;

  int total = 0;
  int bad   = 0;

  ov_t ex[$];
  bit  mf[$];

  always #5 clk = ~clk;

  assign obs = {ALUin1, ALUin2, ALU_outlach, ALU_outEN, G_in, G_out,
                PC_Out, PC_inc, P0_in, P0_out, P1_in, P1_out,
                MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out,
                mem_EN, mem_RW, IR_EN, halted, fault};

  control_unit #(.WAIT_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .MFC          (MFC),
    .ALUin1       (ALUin1),
    .ALUin2       (ALUin2),
    .ALU_outlach  (ALU_outlach),
    .ALU_outEN    (ALU_outEN),
    .G_in         (G_in),
    .G_out        (G_out),
    .PC_Out       (PC_Out),
    .PC_inc       (PC_inc),
    .P0_in        (P0_in),
    .P0_out       (P0_out),
    .P1_in        (P1_in),
    .P1_out       (P1_out),
    .MAR_EN       (MAR_EN),
    .MDR_EN_write (MDR_EN_write),
    .MDR_EN_read  (MDR_EN_read),
    .MDR_out      (MDR_out),
    .mem_EN       (mem_EN),
    .mem_RW       (mem_RW),
    .IR_EN        (IR_EN),
    .halted       (halted),
    .fault        (fault)
  );

  // Leaves the DUT in IDLE just after an edge; that cycle is cycle 0.
  task automatic start(input logic [15:0] v);
    ir  = v;
    MFC = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    start(16'hD000);
    ex = '{Z, F0, F1, F2, Z, F0, F1};
    mf = '{1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = mf[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL reset_nop c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu;
    start(16'h2A00);
    ex = '{Z, F0, F1, F2, Z,
           GO(2) | ALI1, GO(2) | ALI2, ALOL, ALOE | GI(2),
           F0, F1, F2, Z,
           GO(2) | ALI1, GO(2) | ALI2, ALOL, ALOE | GI(2),
           F0};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = 1'b1;
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL alu c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load;
    start(16'h8400);
    ex = '{Z, F0, F1, F2, Z, GO(0) | MAR,
           MEN | MRW, MEN | MRW, MEN | MRW, MEN | MRW | MDR,
           MDO | GI(1), F0};
    mf = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = mf[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL load c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store;
    start(16'h9C00);
    ex = '{Z, F0, F1, F2, Z, GO(0) | MAR, GO(3) | MDW,
           MEN, MEN, MEN, F0};
    mf = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = mf[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL store c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_short_ops;
    logic [15:0] irs [3];
    irs = '{16'hAC00, 16'hB100, 16'hCA00};
    for (int k = 0; k < 3; k++) begin
      start(irs[k]);
      unique case (k)
        0:       ex = '{Z, F0, F1, F2, Z, P1I, P1O | GI(3), F0};
        1:       ex = '{Z, F0, F1, F2, Z, GO(1) | P0I, F0};
        default: ex = '{Z, F0, F1, F2, Z, GO(2) | GI(2), F0};
      endcase
      for (int i = 0; i < ex.size(); i++) begin
        MFC = 1'b1;
        #1;
        total++;
        if (obs !== ex[i]) begin
          bad++;
          $display("FAIL short ir=%h c%0d got=%h want=%h",
                   irs[k], i, obs, ex[i]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_halt;
    start(16'hF000);
    ex = '{Z, F0, F1, F2, Z, HLT, HLT, HLT, HLT};
    mf = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = mf[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL halt c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== Z) begin
      bad++;
      $display("FAIL halt_rst got=%h want=%h", obs, Z);
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (obs !== F0) begin
      bad++;
      $display("FAIL halt_restart got=%h want=%h", obs, F0);
    end
  endtask

  task automatic test_fault;
    start(16'h2A00);
    ex = '{Z, F0, MEN | MRW, MEN | MRW, MEN | MRW, MEN | MRW, FLT, FLT};
    mf = '{1, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < ex.size(); i++) begin
      MFC = mf[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        bad++;
        $display("FAIL fault c%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rst_mid_wait;
    start(16'h2A00);
    mf = '{1, 1, 0, 0};
    for (int i = 0; i < mf.size(); i++) begin
      MFC = mf[i];
      #1;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    total++;
    if (obs !== (MEN | MRW)) begin
      bad++;
      $display("FAIL mid_wait got=%h want=%h", obs, MEN | MRW);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== Z) begin
      bad++;
      $display("FAIL rst_mid_wait got=%h want=%h", obs, Z);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== Z) begin
      bad++;
      $display("FAIL rst_held got=%h want=%h", obs, Z);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_short_ops();
    test_halt();
    test_fault();
    test_rst_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
